// File: rtl/paralelo_serial_pkg.sv
// Shared definitions for the serial link: character width, comma, state encoding.
// Also used by serial_paralelo so both ends agree on the comma character.
package paralelo_serial_pkg;

  localparam int unsigned CHAR_W     = 8;
  localparam int unsigned BYTE_CNT_W = 16;

  localparam logic [CHAR_W-1:0] COMMA_DEF = 8'hBC;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_SYNC_ENC   = 2'd1;
  localparam logic [1:0] ST_ACTIVE_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_SYNC   = ST_SYNC_ENC,
    ST_ACTIVE = ST_ACTIVE_ENC
  } ps_state_e;

  // Bits needed to hold the value n (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ps_shifter.sv
// MSB-first character shifter: loads a character, shifts it out one bit per edge,
// and flags the cycle in which the last bit is on the line.
module ps_shifter
  import paralelo_serial_pkg::*;
(
  input  logic              i_clk_32f,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [CHAR_W-1:0] i_data,
  output logic              o_serial,
  output logic              o_last_bit
);

  localparam int unsigned BIT_W = $clog2(CHAR_W);

  logic [CHAR_W-1:0] r_sh;
  logic [BIT_W-1:0]  r_bit_cnt;

  // Load has priority; a load always restarts the bit count.
  always_ff @(posedge i_clk_32f) begin
    if (i_reset) begin
      r_sh      <= '0;
      r_bit_cnt <= '0;
    end else if (i_load) begin
      r_sh      <= i_data;
      r_bit_cnt <= '0;
    end else if (i_shift) begin
      r_sh      <= {r_sh[CHAR_W-2:0], 1'b0};
      r_bit_cnt <= r_bit_cnt + BIT_W'(1);
    end
  end

  assign o_serial   = r_sh[CHAR_W-1];
  assign o_last_bit = (r_bit_cnt == BIT_W'(CHAR_W - 1));

endmodule

// File: rtl/paralelo_serial.sv
// Transmit serializer: sends a comma sync run after reset, then data bytes or idle commas.
// Optional accepted-byte counter port enabled by defining PS_BYTE_COUNT_EN.
module paralelo_serial
  import paralelo_serial_pkg::*;
#(
  parameter logic [CHAR_W-1:0] COMMA      = COMMA_DEF,
  parameter int unsigned       SYNC_COUNT = 4
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  input  logic [CHAR_W-1:0]     data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  data_out,
  output logic                  active
`ifdef PS_BYTE_COUNT_EN
  ,
  output logic [BYTE_CNT_W-1:0] byte_count
`endif
);

  localparam int unsigned     CC_W       = cnt_width(SYNC_COUNT);
  localparam logic [CC_W-1:0] LAST_COMMA = CC_W'(SYNC_COUNT - 1);

  ps_state_e         r_state;
  ps_state_e         w_state_nxt;
  logic [CC_W-1:0]   r_comma_cnt;
  logic [CC_W-1:0]   w_comma_cnt_nxt;
  logic              r_active;
  logic              w_active_nxt;
  logic              w_last_bit;
  logic              w_load;
  logic              w_shift;
  logic              w_ready;
  logic [CHAR_W-1:0] w_load_data;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_comma_cnt <= '0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_comma_cnt <= w_comma_cnt_nxt;
      r_active    <= w_active_nxt;
    end
  end

  // Next state, shifter control and handshake.
  always_comb begin
    w_state_nxt     = r_state;
    w_comma_cnt_nxt = r_comma_cnt;
    w_active_nxt    = r_active;
    w_load          = 1'b0;
    w_shift         = 1'b0;
    w_ready         = 1'b0;
    w_load_data     = COMMA;

    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_SYNC;
        w_load      = 1'b1;
      end
      ST_SYNC: begin
        w_shift = !w_last_bit;
        w_load  = w_last_bit;
        // The final sync comma already offers the next slot to the data side.
        w_ready = w_last_bit && (r_comma_cnt == LAST_COMMA);
        if (w_last_bit) begin
          w_comma_cnt_nxt = r_comma_cnt + CC_W'(1);
          if (r_comma_cnt == LAST_COMMA) begin
            w_state_nxt  = ST_ACTIVE;
            w_active_nxt = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        w_shift = !w_last_bit;
        w_load  = w_last_bit;
        w_ready = w_last_bit;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_ready && valid_in) begin
      w_load_data = data_in;
    end
  end

  ps_shifter u_shifter (
    .i_clk_32f  (clk_32f),
    .i_reset    (reset),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_data     (w_load_data),
    .o_serial   (data_out),
    .o_last_bit (w_last_bit)
  );

  assign ready_out = w_ready;
  assign active    = r_active;

`ifdef PS_BYTE_COUNT_EN
  logic [BYTE_CNT_W-1:0] r_byte_count;

  // Counts accepted data bytes only; idle commas are not counted.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_byte_count <= '0;
    end else if (w_ready && valid_in) begin
      r_byte_count <= r_byte_count + BYTE_CNT_W'(1);
    end
  end

  assign byte_count = r_byte_count;
`endif

endmodule

// File: tb/tb_paralelo_serial.sv
// Directed self-checking bench for paralelo_serial (default build; byte counter
// scenario included when PS_BYTE_COUNT_EN is defined).
module tb_paralelo_serial;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       active;
`ifdef PS_BYTE_COUNT_EN
  logic [15:0] byte_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_32f = ~clk_32f;

  paralelo_serial #(
    .COMMA      (8'hBC),
    .SYNC_COUNT (4)
  ) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .active     (active)
`ifdef PS_BYTE_COUNT_EN
    ,
    .byte_count (byte_count)
`endif
  );

  task automatic tick();
    @(posedge clk_32f);
    #1;
  endtask

  // Collect 32 line bits starting right after the IDLE->SYNC edge; stops on the
  // sample of the 4th comma's last bit.
  task automatic run_sync(output logic [31:0] bits, output int ridx,
                          output int rcnt, output logic act);
    bits = '0; ridx = -1; rcnt = 0; act = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bits[31-i] = data_out;
      if (ready_out === 1'b1) begin
        ridx = i;
        rcnt++;
      end
      if (active !== 1'b0) act = 1'b1;
      if (i < 31) tick();
    end
  endtask

  // Entered with ready_out=1: offer one slot, collect the 8 bits it produces,
  // and end on the sample where the next ready_out is due.
  task automatic xfer(input logic [7:0] d, input logic v, input logic noise,
                      output logic [7:0] got, output logic rok, output logic act_all);
    data_in  = d;
    valid_in = v;
    tick();
    valid_in = noise;
    data_in  = noise ? 8'h00 : d;
    rok = 1'b1; act_all = 1'b1; got = '0;
    for (int i = 0; i < 8; i++) begin
      got[7-i] = data_out;
      if (active !== 1'b1) act_all = 1'b0;
      if (i < 7) begin
        if (ready_out !== 1'b0) rok = 1'b0;
        tick();
      end else if (ready_out !== 1'b1) begin
        rok = 1'b0;
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] bits;
    int          ridx, rcnt;
    logic        act;
    reset = 1'b1; valid_in = 1'b0; data_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (data_out !== 1'b0 || ready_out !== 1'b0 || active !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state cyc%0d: data_out=%b ready_out=%b active=%b, expected 0 0 0",
                 i, data_out, ready_out, active);
      end
    end
    reset = 1'b0;
    tick();
    run_sync(bits, ridx, rcnt, act);
    n_tests++;
    if (bits !== 32'hBCBCBCBC) begin
      n_fail++; $display("FAIL sync_bits: got %h, expected bcbcbcbc", bits);
    end
    n_tests++;
    if (ridx !== 31 || rcnt !== 1) begin
      n_fail++; $display("FAIL sync_ready: first at %0d count %0d, expected 31 and 1", ridx, rcnt);
    end
    n_tests++;
    if (act !== 1'b0) begin
      n_fail++; $display("FAIL sync_active_early: active seen during sync run");
    end
    tick();
    n_tests++;
    if (active !== 1'b1 || data_out !== 1'b1 || ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL active_rise: active=%b data_out=%b ready_out=%b, expected 1 1 0",
               active, data_out, ready_out);
    end
  endtask

  task automatic test_first_byte();
    logic [31:0] bits;
    int          ridx, rcnt;
    logic        act, rok, aall;
    logic [7:0]  got;
    reset = 1'b1; valid_in = 1'b1; data_in = 8'hA5;
    tick(); tick();
    reset = 1'b0;
    tick();
    run_sync(bits, ridx, rcnt, act);
    n_tests++;
    if (bits !== 32'hBCBCBCBC || ridx !== 31) begin
      n_fail++; $display("FAIL first_sync: bits %h ready at %0d, expected bcbcbcbc at 31", bits, ridx);
    end
    xfer(8'hA5, 1'b1, 1'b0, got, rok, aall);
    n_tests++;
    if (got !== 8'hA5 || rok !== 1'b1 || aall !== 1'b1) begin
      n_fail++;
      $display("FAIL first_byte: got %h ready_ok=%b active_ok=%b, expected a5 1 1", got, rok, aall);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [3];
    logic [7:0] got;
    logic       rok, aall;
    vec[0] = 8'h01; vec[1] = 8'hFF; vec[2] = 8'h80;
    for (int i = 0; i < 3; i++) begin
      xfer(vec[i], 1'b1, 1'b0, got, rok, aall);
      n_tests++;
      if (got !== vec[i] || rok !== 1'b1 || aall !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got %h ready_ok=%b active_ok=%b, expected %h 1 1",
                 i, got, rok, aall, vec[i]);
      end
    end
  endtask

  task automatic test_idle_insertion();
    logic [7:0] got;
    logic       rok, aall;
    xfer(8'h3C, 1'b1, 1'b0, got, rok, aall);
    n_tests++;
    if (got !== 8'h3C || rok !== 1'b1) begin
      n_fail++; $display("FAIL idle_pre: got %h ready_ok=%b, expected 3c 1", got, rok);
    end
    // No byte offered at the slot; valid_in pulses between slots must be ignored.
    xfer(8'h55, 1'b0, 1'b1, got, rok, aall);
    n_tests++;
    if (got !== 8'hBC || rok !== 1'b1 || aall !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_comma: got %h ready_ok=%b active_ok=%b, expected bc 1 1", got, rok, aall);
    end
    xfer(8'hC3, 1'b1, 1'b0, got, rok, aall);
    n_tests++;
    if (got !== 8'hC3 || aall !== 1'b1) begin
      n_fail++; $display("FAIL idle_post: got %h active_ok=%b, expected c3 1", got, aall);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] bits;
    int          ridx, rcnt;
    logic        act, rok, aall;
    logic [7:0]  got;
    data_in = 8'hFF; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (data_out !== 1'b0 || active !== 1'b0 || ready_out !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset cyc%0d: data_out=%b active=%b ready_out=%b, expected 0 0 0",
                 i, data_out, active, ready_out);
      end
    end
    reset = 1'b0; valid_in = 1'b1; data_in = 8'h77;
    tick();
    run_sync(bits, ridx, rcnt, act);
    n_tests++;
    if (bits !== 32'hBCBCBCBC || ridx !== 31 || rcnt !== 1 || act !== 1'b0) begin
      n_fail++;
      $display("FAIL resync: bits %h ready %0d/%0d act=%b, expected bcbcbcbc 31/1 0",
               bits, ridx, rcnt, act);
    end
    xfer(8'h77, 1'b1, 1'b0, got, rok, aall);
    n_tests++;
    if (got !== 8'h77 || rok !== 1'b1) begin
      n_fail++; $display("FAIL resync_byte: got %h ready_ok=%b, expected 77 1", got, rok);
    end
  endtask

`ifdef PS_BYTE_COUNT_EN
  task automatic test_byte_count();
    logic [31:0] bits;
    int          ridx, rcnt;
    logic        act, rok, aall;
    logic [7:0]  got;
    logic [7:0]  d   [5];
    logic        v   [5];
    logic [7:0]  exp [5];
    d[0] = 8'h11; v[0] = 1'b1; exp[0] = 8'h11;
    d[1] = 8'h99; v[1] = 1'b0; exp[1] = 8'hBC;
    d[2] = 8'h22; v[2] = 1'b1; exp[2] = 8'h22;
    d[3] = 8'h99; v[3] = 1'b0; exp[3] = 8'hBC;
    d[4] = 8'h33; v[4] = 1'b1; exp[4] = 8'h33;
    reset = 1'b1; valid_in = 1'b0;
    tick(); tick();
    n_tests++;
    if (byte_count !== 16'd0) begin
      n_fail++; $display("FAIL bc_reset: byte_count=%0d, expected 0", byte_count);
    end
    reset = 1'b0;
    tick();
    run_sync(bits, ridx, rcnt, act);
    for (int i = 0; i < 5; i++) begin
      xfer(d[i], v[i], 1'b0, got, rok, aall);
      n_tests++;
      if (got !== exp[i]) begin
        n_fail++; $display("FAIL bc_loop[%0d]: got %h, expected %h", i, got, exp[i]);
      end
    end
    n_tests++;
    if (byte_count !== 16'd3) begin
      n_fail++; $display("FAIL bc_count: byte_count=%0d, expected 3", byte_count);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = 8'h00;
    test_reset();
    test_first_byte();
    test_back_to_back();
    test_idle_insertion();
    test_reset_mid();
`ifdef PS_BYTE_COUNT_EN
    test_byte_count();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
